// File: rtl/therm_dac_driver.sv
// Binary-to-inverted-thermometer driver for the 16-element unary DAC array.
// Ramps the registered thermometer code toward an accepted target, holds it, then pulses settled.
module therm_dac_driver #(
  parameter int N_BITS        = 4,
  parameter int MAX_STEP      = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     in_code,
  output logic [2**N_BITS-1:0]  therm_out,
  output logic [N_BITS-1:0]     cur_code,
  output logic                  busy,
  output logic                  settled
);

  localparam int THERM_W = 2**N_BITS;
  localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [N_BITS-1:0] STEP        = N_BITS'(MAX_STEP);
  localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [THERM_W-1:0] THERM_ZERO = {{(THERM_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_e;

  state_e              state_q;
  logic [N_BITS-1:0]   curCode_q;
  logic [N_BITS-1:0]   curCode_d;
  logic [N_BITS-1:0]   target_q;
  logic [THERM_W-1:0]  therm_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                settled_q;
  logic                ready_q;
  logic [N_BITS-1:0]   gapUp;
  logic [N_BITS-1:0]   gapDown;

  // Code n clears the low n+1 elements; everything above stays set.
  function automatic logic [THERM_W-1:0] encode(input logic [N_BITS-1:0] code);
    logic [THERM_W-1:0] t;
    for (int i = 0; i < THERM_W; i++) begin
      t[i] = (i > int'(code));
    end
    return t;
  endfunction

  always_comb begin
    gapUp     = target_q - curCode_q;
    gapDown   = curCode_q - target_q;
    curCode_d = curCode_q;
    if (target_q > curCode_q) begin
      curCode_d = (gapUp > STEP) ? curCode_q + STEP : target_q;
    end else if (target_q < curCode_q) begin
      curCode_d = (gapDown > STEP) ? curCode_q - STEP : target_q;
    end
  end

  // therm_out is reloaded from the same next code as cur_code so the two can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      curCode_q <= '0;
      therm_q   <= THERM_ZERO;
      target_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      settled_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            target_q <= in_code;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (in_code != curCode_q) begin
              state_q <= RAMP;
            end else begin
              state_q <= SETTLE;
              cnt_q   <= SETTLE_INIT;
            end
          end
        end
        RAMP: begin
          curCode_q <= curCode_d;
          therm_q   <= encode(curCode_d);
          if (curCode_d == target_q) begin
            state_q <= SETTLE;
            cnt_q   <= SETTLE_INIT;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            settled_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign therm_out = therm_q;
  assign cur_code  = curCode_q;
  assign busy      = busy_q;
  assign settled   = settled_q;

endmodule
